// File: rtl/td4_defs.sv
// rtl/td4_defs.sv - TD4 widths, opcode constants and decoder source-select type
package td4_defs;

  localparam int OP_W   = 4;
  localparam int DATA_W = 4;
  localparam int INSN_W = 8;

  localparam logic [OP_W-1:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [OP_W-1:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [OP_W-1:0] OP_IN_A     = 4'b0010;
  localparam logic [OP_W-1:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [OP_W-1:0] OP_IN_B     = 4'b0110;
  localparam logic [OP_W-1:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [OP_W-1:0] OP_OUT_B    = 4'b1001;
  localparam logic [OP_W-1:0] OP_OUT_IM   = 4'b1011;
  localparam logic [OP_W-1:0] OP_JNC      = 4'b1110;
  localparam logic [OP_W-1:0] OP_JMP      = 4'b1111;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_e;

endpackage

// File: rtl/td4_core_if.sv
// rtl/td4_core_if.sv - program-memory fetch bus between core and instruction ROM
interface td4_core_if;
  import td4_defs::*;

  logic [DATA_W-1:0] ADDR;
  logic [INSN_W-1:0] INSN;

  modport master (output ADDR, input INSN);
  modport slave  (input ADDR, output INSN);

endinterface

// File: rtl/td4_decoder.sv
// rtl/td4_decoder.sv - combinational opcode decode to source select, load enables and jump
module td4_decoder
  import td4_defs::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic            carry_i,
  output src_sel_e        src_sel_o,
  output logic            ld_a_o,
  output logic            ld_b_o,
  output logic            ld_out_o,
  output logic            jump_o
);

  always_comb begin
    src_sel_o = SRC_ZERO;
    ld_a_o    = 1'b0;
    ld_b_o    = 1'b0;
    ld_out_o  = 1'b0;
    jump_o    = 1'b0;
    unique case (op_i)
      OP_ADD_A_IM: begin src_sel_o = SRC_A;    ld_a_o   = 1'b1; end
      OP_MOV_A_B:  begin src_sel_o = SRC_B;    ld_a_o   = 1'b1; end
      OP_IN_A:     begin src_sel_o = SRC_IN;   ld_a_o   = 1'b1; end
      OP_MOV_A_IM: begin src_sel_o = SRC_ZERO; ld_a_o   = 1'b1; end
      OP_MOV_B_A:  begin src_sel_o = SRC_A;    ld_b_o   = 1'b1; end
      OP_ADD_B_IM: begin src_sel_o = SRC_B;    ld_b_o   = 1'b1; end
      OP_IN_B:     begin src_sel_o = SRC_IN;   ld_b_o   = 1'b1; end
      OP_MOV_B_IM: begin src_sel_o = SRC_ZERO; ld_b_o   = 1'b1; end
      OP_OUT_B:    begin src_sel_o = SRC_B;    ld_out_o = 1'b1; end
      OP_OUT_IM:   begin src_sel_o = SRC_ZERO; ld_out_o = 1'b1; end
      // carry_i is the flag from the previous instruction, not this one's ALU result
      OP_JNC:      jump_o = ~carry_i;
      OP_JMP:      jump_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/td4_core.sv
// rtl/td4_core.sv - single-cycle TD4 execution core: registers, ALU adder and PC mux
module td4_core
  import td4_defs::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  td4_core_if.master        imem,
  input  logic [DATA_W-1:0] IN_PORT,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic              CARRY
);

  logic [DATA_W-1:0] pc_q,  pc_d;
  logic [DATA_W-1:0] a_q,   a_d;
  logic [DATA_W-1:0] b_q,   b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              c_q,   c_d;

  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] im;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;
  src_sel_e          src_sel;
  logic              ld_a, ld_b, ld_out, jump;

  assign op = imem.INSN[INSN_W-1:INSN_W-OP_W];
  assign im = imem.INSN[DATA_W-1:0];

  td4_decoder u_dec (
    .op_i      (op),
    .carry_i   (c_q),
    .src_sel_o (src_sel),
    .ld_a_o    (ld_a),
    .ld_b_o    (ld_b),
    .ld_out_o  (ld_out),
    .jump_o    (jump)
  );

  always_comb begin
    src = '0;
    unique case (src_sel)
      SRC_A:    src = a_q;
      SRC_B:    src = b_q;
      SRC_IN:   src = IN_PORT;
      SRC_ZERO: src = '0;
      default:  src = '0;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, im};

  // Every executed instruction, including jumps and NOPs, reloads carry from the adder
  always_comb begin
    pc_d  = pc_q;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    c_d   = c_q;
    if (EN) begin
      pc_d = jump ? im : pc_q + 1'b1;
      c_d  = sum[DATA_W];
      if (ld_a)   a_d   = sum[DATA_W-1:0];
      if (ld_b)   b_d   = sum[DATA_W-1:0];
      if (ld_out) out_d = sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      c_q   <= c_d;
    end
  end

  assign imem.ADDR = pc_q;
  assign OUT_PORT  = out_q;
  assign CARRY     = c_q;

endmodule

// File: tb/tb_td4_core.sv
// tb/tb_td4_core.sv - directed self-checking bench for td4_core with a ROM model
module tb_td4_core;
  import td4_defs::*;

  logic              CLK;
  logic              RST_N;
  logic              EN;
  logic [DATA_W-1:0] IN_PORT;
  logic [DATA_W-1:0] OUT_PORT;
  logic              CARRY;
  logic [7:0]        rom [16];

  int n_cmp;
  int n_bad;

  td4_core_if imem ();

  assign imem.INSN = rom[imem.ADDR];

  td4_core dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .EN       (EN),
    .imem     (imem),
    .IN_PORT  (IN_PORT),
    .OUT_PORT (OUT_PORT),
    .CARRY    (CARRY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic restart();
    @(negedge CLK);
    RST_N = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    RST_N   = 1'b0;
    EN      = 1'b1;
    IN_PORT = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0] = 8'h35; rom[1] = 8'h40; rom[2] = 8'h90; rom[3] = 8'h01;
    #2;
    check("rst_addr",  imem.ADDR, 4'h0);
    check("rst_carry", {3'b0, CARRY}, 4'h0);
    check("rst_out",   OUT_PORT, 4'h0);
    check("rst_a",     dut.a_q, 4'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // MOV A,5; MOV B,A; OUT B
    steps(3);
    check("p1_a",     dut.a_q, 4'h5);
    check("p1_b",     dut.b_q, 4'h5);
    check("p1_out",   OUT_PORT, 4'h5);
    check("p1_pc",    imem.ADDR, 4'h3);
    check("p1_carry", {3'b0, CARRY}, 4'h0);

    // Hold for 5 edges, then resume at address 3 (ADD A,1)
    EN = 1'b0;
    steps(5);
    check("hold_pc",  imem.ADDR, 4'h3);
    check("hold_a",   dut.a_q, 4'h5);
    check("hold_b",   dut.b_q, 4'h5);
    check("hold_out", OUT_PORT, 4'h5);
    check("hold_c",   {3'b0, CARRY}, 4'h0);
    EN = 1'b1;
    steps(1);
    check("resume_a",  dut.a_q, 4'h6);
    check("resume_pc", imem.ADDR, 4'h4);

    // Asynchronous reset pulse between edges
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_out", OUT_PORT, 4'h0);
    check("arst_a",   dut.a_q, 4'h0);
    check("arst_b",   dut.b_q, 4'h0);
    check("arst_pc",  imem.ADDR, 4'h0);
    check("arst_c",   {3'b0, CARRY}, 4'h0);
    RST_N = 1'b1;
    steps(1);
    check("arst_restart_a", dut.a_q, 4'h5);

    // MOV A,F; ADD A,1; JNC 0 -> not taken
    restart();
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0;
    steps(2);
    check("jnc_a",     dut.a_q, 4'h0);
    check("jnc_c_set", {3'b0, CARRY}, 4'h1);
    steps(1);
    check("jnc_nt_pc", imem.ADDR, 4'h3);
    check("jnc_c_clr", {3'b0, CARRY}, 4'h0);

    // MOV A,1; JNC 7 -> taken
    restart();
    rom[0] = 8'h31; rom[1] = 8'hE7;
    steps(1);
    check("jnc_pre_c", {3'b0, CARRY}, 4'h0);
    steps(1);
    check("jnc_t_pc",  imem.ADDR, 4'h7);

    // JMP C at address 5, then NOPs through 15 wrap to 0
    restart();
    rom[5] = 8'hFC;
    steps(6);
    check("jmp_pc",  imem.ADDR, 4'hC);
    steps(4);
    check("wrap_pc", imem.ADDR, 4'h0);

    // IN B; OUT B; IN A with im=8 on IN_PORT=9
    restart();
    IN_PORT = 4'h9;
    rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'h28;
    steps(2);
    check("in_b",   dut.b_q, 4'h9);
    check("in_out", OUT_PORT, 4'h9);
    steps(1);
    check("in_a",   dut.a_q, 4'h1);
    check("in_c",   {3'b0, CARRY}, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
